// File: rtl/ps2_key_encoder_pkg.sv
// Shared constants, decoder state type and ps2_key field positions for the
// PS/2 scancode-set-2 key encoder.
package ps2_pkg;

  localparam int unsigned KEY_W       = 11;
  localparam int unsigned CODE_W      = 8;
  localparam int unsigned KEY_TOGGLE  = 10;
  localparam int unsigned KEY_PRESSED = 9;
  localparam int unsigned KEY_EXT     = 8;
  localparam int unsigned FRAME_BITS  = 11;
  localparam int unsigned BITCNT_W    = 4;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_dec_t;

endpackage

// File: rtl/ps2_key_encoder_if.sv
// PS/2 pin inputs and key-event outputs of the encoder.
//   ps2_clk_in, ps2_dat_in : raw asynchronous PS/2 lines
//   ps2_key                : [10] toggle, [9] pressed, [8] extended, [7:0] code
//   frame_err              : one-cycle pulse on a rejected/timed-out frame
//   busy                   : a frame is partially received
interface ps2_key_encoder_if;
  import ps2_pkg::*;

  logic              ps2_clk_in;
  logic              ps2_dat_in;
  logic [KEY_W-1:0]  ps2_key;
  logic              frame_err;
  logic              busy;

  // slave: the encoder; master: whoever drives the pins and consumes events
  modport slave  (input ps2_clk_in, ps2_dat_in, output ps2_key, frame_err, busy);
  modport master (output ps2_clk_in, ps2_dat_in, input ps2_key, frame_err, busy);
endinterface

// File: rtl/ps2_key_encoder_line_filter.sv
// Synchronises the raw PS/2 lines, glitch-filters the clock and emits a
// one-cycle strobe on each filtered falling edge with the matching data bit.
//   CLK, RESET        : system clock, async active-high reset
//   ps2_clk_in/dat_in : raw asynchronous lines
//   strobe            : one-cycle pulse on filtered 1->0 of the PS/2 clock
//   dat               : synchronised data, valid while strobe is high
module ps2_line_filter #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic strobe,
  output logic dat
);

  localparam int unsigned CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt_clk;
  logic [CW-1:0] cnt;

  // Lines idle high, so synchroniser and filter reset to 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_clk <= 1'b1;
      cnt      <= '0;
      strobe   <= 1'b0;
      dat      <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      dat      <= dat_sync[1];
      strobe   <= 1'b0;
      // Count consecutive samples that disagree with the filtered level.
      if (clk_sync[1] != filt_clk) begin
        if (cnt == CW'(FILTER_CYCLES - 1)) begin
          filt_clk <= clk_sync[1];
          cnt      <= '0;
          strobe   <= filt_clk & ~clk_sync[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, folds E0/F0 prefixes
// and publishes each key event as an 11-bit toggle-format word.
//   CLK, RESET : system clock, async active-high reset
//   bus        : slave side of ps2_key_encoder_if (pins in, key/err/busy out)
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  ps2_key_encoder_if.slave      bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic strobe;
  logic dat;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .CLK        (CLK),
    .RESET      (RESET),
    .ps2_clk_in (bus.ps2_clk_in),
    .ps2_dat_in (bus.ps2_dat_in),
    .strobe     (strobe),
    .dat        (dat)
  );

  logic [BITCNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [9:0]          shreg, shreg_n;
  logic [WD_W-1:0]     wd, wd_n;
  logic                busy_q;
  logic                last_bit_c;
  logic                timeout_c;
  logic                frame_ok_c;
  logic                err_c;
  logic [7:0]          code_c;

  ps2_dec_t         state, state_n;
  logic [KEY_W-1:0] key_q, key_n;
  logic             err_q;

  // shreg collects start (bit 0), data (8:1) and parity (9); stop arrives live.
  assign last_bit_c = strobe && (bit_cnt == BITCNT_W'(FRAME_BITS - 1));
  assign timeout_c  = !strobe && (bit_cnt != '0) && (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign code_c     = shreg[8:1];
  assign frame_ok_c = last_bit_c && !shreg[0] && (^shreg[9:1]) && dat;
  assign err_c      = (last_bit_c && !frame_ok_c) || timeout_c;

  // Frame counter, shift register and watchdog next-state.
  always_comb begin
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    wd_n      = '0;
    if (strobe) begin
      if (last_bit_c) begin
        bit_cnt_n = '0;
      end else begin
        bit_cnt_n = bit_cnt + BITCNT_W'(1);
        shreg_n   = {dat, shreg[9:1]};
      end
    end else if (bit_cnt != '0) begin
      if (timeout_c) begin
        bit_cnt_n = '0;
      end else begin
        wd_n = wd + WD_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt <= '0;
      shreg   <= '0;
      wd      <= '0;
      busy_q  <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      wd      <= wd_n;
      busy_q  <= (bit_cnt_n != '0);
    end
  end

  // Decoder state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      key_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      key_q <= key_n;
      err_q <= err_c;
    end
  end

  // Prefix folding and event generation.
  always_comb begin
    state_n = state;
    key_n   = key_q;
    if (err_c) begin
      state_n = IDLE;
    end else if (frame_ok_c) begin
      case (code_c)
        PS2_EXT: state_n = EXT;
        PS2_BRK: begin
          case (state)
            IDLE:    state_n = BRK;
            EXT:     state_n = EXT_BRK;
            default: state_n = state;
          endcase
        end
        PS2_ACK, PS2_BAT, PS2_ECHO, PS2_RESEND, PS2_ERR0, PS2_ERR1: state_n = IDLE;
        default: begin
          key_n = {~key_q[KEY_TOGGLE],
                   ~((state == BRK) || (state == EXT_BRK)),
                   (state == EXT) || (state == EXT_BRK),
                   code_c};
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: drives a PS/2 keyboard model (timebase
// and watchdog scaled down to keep the run short) and checks the key word,
// error pulses and busy flag against hand-computed values.
module tb_ps2_key_encoder;
  import ps2_pkg::*;

  localparam int unsigned HALF     = 50;     // CLK cycles per PS/2 half period
  localparam int unsigned TIMEOUT  = 4800;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   passed = 0;
  int   err_cycles = 0;

  ps2_key_encoder_if bus ();

  ps2_key_encoder #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(TIMEOUT)) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #10 CLK = ~CLK;

  // Count every cycle frame_err is high; single pulses keep this equal to the pulse count.
  always @(negedge CLK) if (bus.frame_err === 1'b1) err_cycles++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_dat_in = b;
    wait_clk(HALF);
    bus.ps2_clk_in = 1'b0;
    wait_clk(HALF);
    bus.ps2_clk_in = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_parity);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_parity, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    bus.ps2_dat_in = 1'b1;
    wait_clk(HALF);
  endtask

  initial begin
    int e0;
    RESET = 1'b1;
    bus.ps2_clk_in = 1'b1;
    bus.ps2_dat_in = 1'b1;
    wait_clk(5);
    @(negedge CLK);
    check("reset_key",  16'(bus.ps2_key), 16'h000);
    check("reset_busy", 16'(bus.busy), 16'h0);
    check("reset_err",  16'(bus.frame_err), 16'h0);
    RESET = 1'b0;
    wait_clk(5);

    // 1: make code
    send_byte(8'h29, 1'b0);
    @(negedge CLK);
    check("make_29", 16'(bus.ps2_key), 16'h629);
    check("busy_after_stop", 16'(bus.busy), 16'h0);

    // 2: break code, nothing after F0 alone
    send_byte(8'hF0, 1'b0);
    @(negedge CLK);
    check("no_event_f0", 16'(bus.ps2_key), 16'h629);
    send_byte(8'h29, 1'b0);
    @(negedge CLK);
    check("break_29", 16'(bus.ps2_key), 16'h029);

    // 3: extended make/break, then plain code clears ext
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    @(negedge CLK);
    check("ext_make_75", 16'(bus.ps2_key), 16'h775);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    @(negedge CLK);
    check("ext_break_75", 16'(bus.ps2_key), 16'h175);
    send_byte(8'h1C, 1'b0);
    @(negedge CLK);
    check("plain_1c", 16'(bus.ps2_key), 16'h61C);

    // controller reply after E0 cancels the prefix
    send_byte(8'hE0, 1'b0);
    send_byte(8'hAA, 1'b0);
    @(negedge CLK);
    check("bat_no_event", 16'(bus.ps2_key), 16'h61C);
    send_byte(8'h1C, 1'b0);
    @(negedge CLK);
    check("after_bat_1c", 16'(bus.ps2_key), 16'h21C);

    // 4: parity error
    e0 = err_cycles;
    send_byte(8'h29, 1'b1);
    @(negedge CLK);
    check("parity_err_pulse", 16'(err_cycles - e0), 16'd1);
    check("parity_key_hold", 16'(bus.ps2_key), 16'h21C);
    send_byte(8'h16, 1'b0);
    @(negedge CLK);
    check("after_err_16", 16'(bus.ps2_key), 16'h616);

    // 5: watchdog timeout after 4 bits
    e0 = err_cycles;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_clk(TIMEOUT - 100);
    @(negedge CLK);
    check("timeout_not_yet", 16'(err_cycles - e0), 16'd0);
    check("timeout_busy_hi", 16'(bus.busy), 16'h1);
    wait_clk(300);
    @(negedge CLK);
    check("timeout_pulse", 16'(err_cycles - e0), 16'd1);
    check("timeout_busy_lo", 16'(bus.busy), 16'h0);
    send_byte(8'h1E, 1'b0);
    @(negedge CLK);
    check("after_timeout_1e", 16'(bus.ps2_key), 16'h21E);

    // 6: reply byte, glitches mid-frame, reset mid-frame
    send_byte(8'hFA, 1'b0);
    @(negedge CLK);
    check("ack_no_event", 16'(bus.ps2_key), 16'h21E);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    for (int g = 0; g < 2; g++) begin
      wait_clk(20);
      bus.ps2_clk_in = 1'b0;
      wait_clk(2);
      bus.ps2_clk_in = 1'b1;
    end
    wait_clk(20);
    @(negedge CLK);
    check("glitch_bitcnt", 16'(u_dut.bit_cnt), 16'd4);
    check("glitch_busy", 16'(bus.busy), 16'h1);
    e0 = err_cycles;
    #3 RESET = 1'b1;
    #1;
    check("rst_key_async",  16'(bus.ps2_key), 16'h000);
    check("rst_busy_async", 16'(bus.busy), 16'h0);
    wait_clk(3);
    @(negedge CLK);
    RESET = 1'b0;
    wait_clk(5);
    send_byte(8'h29, 1'b0);
    @(negedge CLK);
    check("post_reset_29", 16'(bus.ps2_key), 16'h629);
    check("post_reset_noerr", 16'(err_cycles - e0), 16'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
